cv32e40px_x_result_arb: RTL and testbench
=========================================

# cv32e40px_x_result_arb

Round-robin arbiter that merges the result channels of N_COPROC coprocessors onto the single core-side X-interface result channel of the cv32e40px. It sits between the coprocessors and the core's result port, so several extensions can share the core's scoreboard-clearing writeback path. Each winning result passes through one registered output stage: one cycle of latency, one result per cycle. Every coprocessor sees a standard valid/ready handshake and is never starved.

## Interface
- N_COPROC, 2: number of coprocessor result requesters (2..8).
- XLEN, 32: result data width.
- ID_W, 4: instruction ID width, matches the issue/commit ID.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  synchronous active-high reset.
- cp_result_valid_i  in  N_COPROC  per-coprocessor result valid.
- cp_result_ready_o  out  N_COPROC  per-coprocessor result ready (accept strobe).
- cp_result_id_i  in  N_COPROC×ID_W  result instruction ID.
- cp_result_data_i  in  N_COPROC×XLEN  result data.
- cp_result_rd_i  in  N_COPROC×5  destination register.
- cp_result_we_i  in  N_COPROC  register write enable.
- x_result_valid_o  out  1  merged result valid (registered).
- x_result_ready_i  in  1  core ready; the core currently ties it to 1, but the block must honour 0.
- x_result_id_o  out  ID_W  registered ID.
- x_result_data_o  out  XLEN  registered data.
- x_result_rd_o  out  5  registered rd.
- x_result_we_o  out  1  registered we.
- x_result_src_o  out  $clog2(N_COPROC)  index of the coprocessor that produced the held result.

## Operation
- State: output register out_q (valid, id, data, rd, we, src) and round-robin pointer ptr_q (width $clog2(N_COPROC)).
- load_en = ~out_valid_q | x_result_ready_i. The output stage takes a new entry when it is empty or is being drained in the same cycle.
- Arbitration (combinational):
  - Scan requesters ptr_q, ptr_q+1, …, wrapping modulo N_COPROC.
  - The first one with cp_result_valid_i set wins (grant one-hot, winner index w).
  - No valid requester: no grant.
- cp_result_ready_o[i] = grant[i] & load_en. At most one bit is high per cycle; all others are 0.
- Accepted result (grant & load_en):
  - out_q ← payload of w, with valid=1 and src=w.
  - ptr_q ← (w+1) mod N_COPROC. The wrap for non-power-of-2 N_COPROC is an explicit compare, not bit truncation.
- Drain with no new grant (x_result_ready_i & no grant): out_valid_q ← 0. The payload holds its last value.
- Stall (out_valid_q & ~x_result_ready_i):
  - All cp_result_ready_o stay 0.
  - out_q and ptr_q hold.
  - Output payload is bit-stable while valid and not ready.
- ptr_q changes only on an accepted grant. An idle cycle does not advance it.
- Fairness: a requester holding valid waits at most N_COPROC−1 grants to others.
- A coprocessor must keep payload stable while valid & ~ready. The block does not check this.
- x_result_we_o is passed through unchanged. Scoreboard clearing remains the core's responsibility.

## Timing
- Reset (rst_i=1 at an edge):
  - out_valid_q=0, id/data/rd/we/src=0, ptr_q=0.
  - All outputs read 0 the following cycle.
  - cp_result_ready_o reads 0 while rst_i is high, regardless of load_en.
- Reset mid-operation: a held, undelivered result is discarded. Coprocessors see no handshake in that cycle.
- Latency: a result accepted at edge k appears on x_result_*_o from edge k until it is consumed. That is one cycle after the coprocessor handshake cycle.
- Throughput:
  - With x_result_ready_i=1, one result per cycle back-to-back.
  - With ready toggling, the output stage refills in the same cycle it drains (no bubble).
- Simultaneous events:
  - Drain and new grant in the same cycle: out_q is overwritten with the new entry and valid stays 1.
  - All N requesters valid: grants rotate strictly in index order starting at ptr_q.

## Test plan
- Single requester: N=2, cp1 valid with id=3, rd=7, data=0xDEADBEEF, we=1, ready_i=1.
  - Expected: cp_result_ready_o=2'b10 in cycle 0; next cycle x_result_valid_o=1, id=3, rd=7, data=0xDEADBEEF, src=1; ptr_q=0.
- Contention rotation: N=3, all valid continuously, ready_i=1.
  - Expected: grant order 0,1,2,0,1,2 over 6 cycles; x_result_valid_o stays high from cycle 1.
- Backpressure: hold ready_i=0 for 3 cycles while out_q is valid and cp0/cp1 are valid.
  - Expected: outputs bit-stable, all cp ready=0, ptr unchanged.
  - On ready_i=1: same-cycle refill, next result appears the next cycle with no bubble.
- Idle pointer hold: grant cp0 (ptr→1), then 4 idle cycles, then cp0 and cp1 valid.
  - Expected: cp1 is granted first; x_result_valid_o=0 during the idle cycles after drain.
- Reset mid-operation: out_q valid with id=5, assert rst_i for 1 cycle while cp2 (N=3) is valid.
  - Expected: no cp ready during reset; next cycle all outputs 0 and ptr=0; cp2 is granted the cycle after.
- Non-power-of-2 wrap: N=3, ptr=2, only cp0 valid.
  - Expected: cp0 granted, ptr becomes 1, never 3.

Source files
------------

// File: rtl/cv32e40px_x_result_arb.sv
// Round-robin merge of N_COPROC coprocessor result channels onto the
// single core X-interface result channel through one registered stage.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cp_result_*_i/_o      per-coprocessor result channels (flattened)
//   x_result_*_o          registered merged result towards the core
//   x_result_ready_i      core accept strobe
//   x_result_src_o        index of the coprocessor owning the held result
module cv32e40px_x_result_arb #(
    parameter int N_COPROC = 2,
    parameter int XLEN     = 32,
    parameter int ID_W     = 4,
    localparam int SRC_W   = $clog2(N_COPROC)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_COPROC-1:0]      cp_result_valid_i,
    output logic [N_COPROC-1:0]      cp_result_ready_o,
    input  logic [N_COPROC*ID_W-1:0] cp_result_id_i,
    input  logic [N_COPROC*XLEN-1:0] cp_result_data_i,
    input  logic [N_COPROC*5-1:0]    cp_result_rd_i,
    input  logic [N_COPROC-1:0]      cp_result_we_i,
    output logic                     x_result_valid_o,
    input  logic                     x_result_ready_i,
    output logic [ID_W-1:0]          x_result_id_o,
    output logic [XLEN-1:0]          x_result_data_o,
    output logic [4:0]               x_result_rd_o,
    output logic                     x_result_we_o,
    output logic [SRC_W-1:0]         x_result_src_o
);

    localparam logic [SRC_W-1:0] LAST = SRC_W'(N_COPROC - 1);

    logic             r_valid;
    logic [ID_W-1:0]  r_id;
    logic [XLEN-1:0]  r_data;
    logic [4:0]       r_rd;
    logic             r_we;
    logic [SRC_W-1:0] r_src;
    logic [SRC_W-1:0] r_ptr;

    logic                w_load_en;
    logic                w_found;
    logic                w_found_hi;
    logic                w_found_lo;
    logic [SRC_W-1:0]    w_win_hi;
    logic [SRC_W-1:0]    w_win_lo;
    logic [SRC_W-1:0]    w_win;
    logic [N_COPROC-1:0] w_grant;
    logic [SRC_W-1:0]    w_ptr_nxt;
    logic [ID_W-1:0]     w_id;
    logic [XLEN-1:0]     w_data;
    logic [4:0]          w_rd;
    logic                w_we;

    assign w_load_en = ~r_valid | x_result_ready_i;

    // Rotating priority split into two fixed-index scans: the first
    // valid requester at or above the pointer wins; otherwise the
    // first valid requester overall (necessarily below the pointer).
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int i = 0; i < N_COPROC; i++) begin
            if (cp_result_valid_i[i] && !w_found_hi &&
                (SRC_W'(i) >= r_ptr)) begin
                w_found_hi = 1'b1;
                w_win_hi   = SRC_W'(i);
            end
            if (cp_result_valid_i[i] && !w_found_lo) begin
                w_found_lo = 1'b1;
                w_win_lo   = SRC_W'(i);
            end
        end
        w_found = w_found_hi | w_found_lo;
        w_win   = w_found_hi ? w_win_hi : w_win_lo;
    end

    always_comb begin
        w_grant = '0;
        if (w_found) begin
            w_grant[w_win] = 1'b1;
        end
    end

    // Reset masks the strobe so no coprocessor loses a result
    // that is about to be discarded.
    assign cp_result_ready_o =
        w_grant & {N_COPROC{w_load_en & ~rst_i}};

    // Explicit wrap keeps non-power-of-2 counts in range.
    assign w_ptr_nxt = (w_win == LAST) ? '0 : w_win + 1'b1;

    always_comb begin
        w_id   = '0;
        w_data = '0;
        w_rd   = '0;
        w_we   = 1'b0;
        for (int i = 0; i < N_COPROC; i++) begin
            if (w_win == SRC_W'(i)) begin
                w_id   = cp_result_id_i[i*ID_W +: ID_W];
                w_data = cp_result_data_i[i*XLEN +: XLEN];
                w_rd   = cp_result_rd_i[i*5 +: 5];
                w_we   = cp_result_we_i[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_data  <= '0;
            r_rd    <= '0;
            r_we    <= 1'b0;
            r_src   <= '0;
            r_ptr   <= '0;
        end else if (w_load_en) begin
            if (w_found) begin
                r_valid <= 1'b1;
                r_id    <= w_id;
                r_data  <= w_data;
                r_rd    <= w_rd;
                r_we    <= w_we;
                r_src   <= w_win;
                r_ptr   <= w_ptr_nxt;
            end else begin
                // Drained with nothing to refill; payload keeps
                // its last value.
                r_valid <= 1'b0;
            end
        end
    end

    assign x_result_valid_o = r_valid;
    assign x_result_id_o    = r_id;
    assign x_result_data_o  = r_data;
    assign x_result_rd_o    = r_rd;
    assign x_result_we_o    = r_we;
    assign x_result_src_o   = r_src;

endmodule

// File: tb/tb_cv32e40px_x_result_arb.sv
// Scoreboard bench for cv32e40px_x_result_arb with three coprocessors.
// A reference round-robin model predicts grants and queued results.
module tb_cv32e40px_x_result_arb;

    localparam int N    = 3;
    localparam int XLEN = 32;
    localparam int ID_W = 4;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
        logic            we;
        logic [1:0]      src;
    } res_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    vld;
    logic [N-1:0]    cp_rdy;
    logic            rdy;
    logic            x_valid;
    logic [ID_W-1:0] x_id;
    logic [XLEN-1:0] x_data;
    logic [4:0]      x_rd;
    logic            x_we;
    logic [1:0]      x_src;

    logic [ID_W-1:0] p_id   [N];
    logic [XLEN-1:0] p_data [N];
    logic [4:0]      p_rd   [N];
    logic            p_we   [N];

    logic [N*ID_W-1:0] f_id;
    logic [N*XLEN-1:0] f_data;
    logic [N*5-1:0]    f_rd;
    logic [N-1:0]      f_we;

    always_comb begin
        f_id   = '0;
        f_data = '0;
        f_rd   = '0;
        f_we   = '0;
        for (int i = 0; i < N; i++) begin
            f_id[i*ID_W +: ID_W]   = p_id[i];
            f_data[i*XLEN +: XLEN] = p_data[i];
            f_rd[i*5 +: 5]         = p_rd[i];
            f_we[i]                = p_we[i];
        end
    end

    always #5 clk = ~clk;

    cv32e40px_x_result_arb #(
        .N_COPROC(N),
        .XLEN    (XLEN),
        .ID_W    (ID_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cp_result_valid_i(vld),
        .cp_result_ready_o(cp_rdy),
        .cp_result_id_i   (f_id),
        .cp_result_data_i (f_data),
        .cp_result_rd_i   (f_rd),
        .cp_result_we_i   (f_we),
        .x_result_valid_o (x_valid),
        .x_result_ready_i (rdy),
        .x_result_id_o    (x_id),
        .x_result_data_o  (x_data),
        .x_result_rd_o    (x_rd),
        .x_result_we_o    (x_we),
        .x_result_src_o   (x_src)
    );

    int   n_chk = 0;
    int   n_err = 0;
    res_t sb[$];
    int   m_ptr   = 0;
    bit   m_ov    = 0;
    bit   m_zero  = 0;
    bit   m_known = 0;
    bit   refresh = 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic newpay(input int i);
        p_id[i]   = ID_W'($urandom);
        p_data[i] = $urandom;
        p_rd[i]   = 5'($urandom);
        p_we[i]   = 1'($urandom);
    endtask

    task automatic cyc();
        bit         f;
        int         w;
        logic       le;
        logic [2:0] er;
        res_t       e;
        #2;
        le = !m_ov || rdy;
        f  = 0;
        w  = 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (!f && vld[j]) begin
                f = 1;
                w = j;
            end
        end
        er = (f && le && !rst) ? 3'(1 << w) : 3'b000;
        chk("cp_ready", 64'(cp_rdy), 64'(er));
        if (m_known) begin
            chk("x_valid", 64'(x_valid), 64'(m_ov));
            if (m_ov) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 64'(1), 64'(0));
                end else begin
                    e = sb[0];
                    chk("x_id", 64'(x_id), 64'(e.id));
                    chk("x_data", 64'(x_data), 64'(e.data));
                    chk("x_rd", 64'(x_rd), 64'(e.rd));
                    chk("x_we", 64'(x_we), 64'(e.we));
                    chk("x_src", 64'(x_src), 64'(e.src));
                    if (rdy) void'(sb.pop_front());
                end
            end else if (m_zero) begin
                chk("z_payload",
                    {19'(0), x_id, x_data, x_rd, x_we, x_src},
                    64'(0));
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_ptr   = 0;
            m_ov    = 0;
            m_zero  = 1;
            m_known = 1;
            sb.delete();
        end else if (le) begin
            if (f) begin
                e.id   = p_id[w];
                e.data = p_data[w];
                e.rd   = p_rd[w];
                e.we   = p_we[w];
                e.src  = 2'(w);
                sb.push_back(e);
                m_ptr  = (w + 1) % N;
                m_ov   = 1;
                m_zero = 0;
                if (refresh) newpay(w);
            end else begin
                m_ov = 0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        vld = '0;
        for (int i = 0; i < N; i++) newpay(i);

        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // single requester cp1
        p_id[1]   = 4'd3;
        p_rd[1]   = 5'd7;
        p_data[1] = 32'hDEADBEEF;
        p_we[1]   = 1'b1;
        vld = 3'b010;
        cyc();
        vld = 3'b000;
        #2;
        chk("single_id", 64'(x_id), 64'(3));
        chk("single_data", 64'(x_data), 64'h0000_0000_DEAD_BEEF);
        chk("single_src", 64'(x_src), 64'(1));
        cyc();

        // contention, pointer now 2: order 2,0,1,2,0,1
        refresh = 1;
        vld = 3'b111;
        repeat (6) cyc();

        // backpressure with cp0/cp1 pending
        vld = 3'b011;
        cyc();
        rdy = 1'b0;
        repeat (3) cyc();
        rdy = 1'b1;
        repeat (2) cyc();

        // idle pointer hold
        vld = 3'b000;
        repeat (2) cyc();
        vld = 3'b001;
        cyc();
        vld = 3'b000;
        repeat (4) cyc();
        vld = 3'b011;
        #2;
        chk("idle_ptr_grant", 64'(cp_rdy), 64'(3'b010));
        repeat (2) cyc();

        // reset mid-operation with held result
        vld = 3'b000;
        repeat (2) cyc();
        refresh = 0;
        p_id[0] = 4'd5;
        vld = 3'b001;
        cyc();
        rdy = 1'b0;
        p_id[2] = 4'd9;
        vld = 3'b100;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        rdy = 1'b1;
        repeat (2) cyc();

        // non-power-of-2 wrap from pointer 2
        vld = 3'b000;
        repeat (2) cyc();
        vld = 3'b010;
        cyc();
        vld = 3'b001;
        #2;
        chk("wrap_grant", 64'(cp_rdy), 64'(3'b001));
        cyc();
        vld = 3'b011;
        #2;
        chk("wrap_ptr1", 64'(cp_rdy), 64'(3'b010));
        repeat (2) cyc();

        // random traffic
        refresh = 1;
        for (int t = 0; t < 300; t++) begin
            vld = 3'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            cyc();
        end
        vld = 3'b000;
        rdy = 1'b1;
        repeat (3) cyc();
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
